// File: rtl/wordcount_pkg.sv
// Shared types and constants for the word-count accumulator: FSM states,
// the stored entry layout and the value/count widths.
package wordcount_pkg;

  localparam int unsigned COUNT_W = 32;
  localparam int unsigned VALUE_W = 32;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StIdle  = 2'd1,
    StDrain = 2'd2
  } wc_state_e;

  typedef struct packed {
    logic               valid;
    logic [VALUE_W-1:0] value;
    logic [COUNT_W-1:0] count;
  } wc_entry_t;

  localparam wc_entry_t EntryZero = '{valid: 1'b0, value: '0, count: '0};

endpackage

// File: rtl/wc_count_ram.sv
// Simple dual-port entry RAM: one write port, one read port with a registered
// output (1-cycle latency). A same-edge read of a written address returns old data.
module wc_count_ram
  import wordcount_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  wc_entry_t         wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output wc_entry_t         rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  wc_entry_t mem_q [Depth];
  wc_entry_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/word_count_accum.sv
// Word-count accumulation table with 3-stage read-add-write pipeline and drain port.
// Define WORD_COUNT_ACCUM_SATURATE_EN to clamp count overflow (and flag err) instead of wrapping.
module word_count_accum
  import wordcount_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               accum_we,
  input  logic [31:0]        accum_addr,
  input  logic [63:0]        accum_din,
  input  logic               drain_kick,
  output logic               ready,
  output logic               busy,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [VALUE_W-1:0] rd_value,
  output logic [COUNT_W-1:0] rd_count,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  wc_state_e state_q, state_d;
  logic [ADDR_W-1:0] scan_q, scan_d;
  logic              scan_done_q, scan_done_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic               rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [VALUE_W-1:0] rd_value_q, rd_value_d;
  logic [COUNT_W-1:0] rd_count_q, rd_count_d;
  logic               err_q, err_d;

  logic              s0_valid_q, s1_valid_q, s2_valid_q;
  logic [ADDR_W-1:0] s0_addr_q, s1_addr_q, s2_addr_q;
  logic [63:0]       s0_din_q, s1_din_q, s2_din_q;
  wc_entry_t         s2_old_q;

  // Last write-back, kept one cycle to cover the RAM's same-edge read hazard.
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_q;
  wc_entry_t         wb_entry_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  wc_entry_t         ram_wdata, ram_rdata;

  logic               addr_ok, pipe_empty, upd_accept, upd_drop, drain_start;
  logic [COUNT_W-1:0] old_count, new_count;
  logic               ovf_err;
  wc_entry_t          s2_new, s1_old;

  assign addr_ok     = (accum_addr >> ADDR_W) == 32'd0;
  assign pipe_empty  = !(s0_valid_q || s1_valid_q || s2_valid_q);
  assign upd_accept  = accum_we && (state_q == StIdle) && addr_ok;
  assign upd_drop    = accum_we && !upd_accept;
  assign drain_start = drain_kick && !accum_we && (state_q == StIdle) && pipe_empty;

  assign ready = (state_q == StIdle) && pipe_empty;
  assign busy  = !ready;

  assign old_count = s2_old_q.valid ? s2_old_q.count : '0;

`ifdef WORD_COUNT_ACCUM_SATURATE_EN
  logic [COUNT_W:0] sum_wide;
  assign sum_wide  = {1'b0, old_count} + {1'b0, s2_din_q[31:0]};
  assign new_count = sum_wide[COUNT_W] ? '1 : sum_wide[COUNT_W-1:0];
  assign ovf_err   = s2_valid_q && sum_wide[COUNT_W];
`else
  assign new_count = old_count + s2_din_q[31:0];
  assign ovf_err   = 1'b0;
`endif

  assign s2_new = '{valid: 1'b1, value: s2_din_q[63:32], count: new_count};

  // Newest result wins: the entry in S2 is younger than the one just written back.
  always_comb begin
    s1_old = ram_rdata;
    if (wb_valid_q && (wb_addr_q == s1_addr_q)) begin
      s1_old = wb_entry_q;
    end
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      s1_old = s2_new;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s2_addr_q;
    ram_wdata = s2_new;
    if (state_q == StInit) begin
      ram_we    = 1'b1;
      ram_waddr = scan_q;
      ram_wdata = EntryZero;
    end else if (state_q == StDrain) begin
      ram_we    = rd_valid_q && rd_ready;
      ram_waddr = rd_addr_q;
      ram_wdata = EntryZero;
    end else begin
      ram_we = s2_valid_q;
    end
  end

  assign ram_raddr = (state_q == StDrain) ? scan_q : s0_addr_q;

  wc_count_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    scan_done_d = scan_done_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    rd_valid_d  = rd_valid_q;
    rd_addr_d   = rd_addr_q;
    rd_value_d  = rd_value_q;
    rd_count_d  = rd_count_q;
    err_d       = err_q || upd_drop || ovf_err;
    unique case (state_q)
      StInit: begin
        scan_d = scan_q + ADDR_W'(1);
        if (scan_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (drain_start) begin
          state_d     = StDrain;
          scan_d      = '0;
          scan_done_d = 1'b0;
        end
      end
      StDrain: begin
        if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
        end
        if (pend_q && ram_rdata.valid) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = pend_addr_q;
          rd_value_d = ram_rdata.value;
          rd_count_d = ram_rdata.count;
        end else if (!rd_valid_q && !scan_done_q) begin
          // Issue the next scan read; the result is inspected next cycle.
          pend_d      = 1'b1;
          pend_addr_d = scan_q;
          scan_d      = scan_q + ADDR_W'(1);
          if (scan_q == LastAddr) begin
            scan_done_d = 1'b1;
          end
        end else if (!rd_valid_q && scan_done_q && !pend_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      scan_q      <= '0;
      scan_done_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_value_q  <= '0;
      rd_count_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      scan_done_q <= scan_done_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      rd_value_q  <= rd_value_d;
      rd_count_q  <= rd_count_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
      s0_addr_q  <= '0;
      s1_addr_q  <= '0;
      s2_addr_q  <= '0;
      wb_addr_q  <= '0;
      s0_din_q   <= '0;
      s1_din_q   <= '0;
      s2_din_q   <= '0;
      s2_old_q   <= EntryZero;
      wb_entry_q <= EntryZero;
    end else begin
      s0_valid_q <= upd_accept;
      if (upd_accept) begin
        s0_addr_q <= accum_addr[ADDR_W-1:0];
        s0_din_q  <= accum_din;
      end
      s1_valid_q <= s0_valid_q;
      s1_addr_q  <= s0_addr_q;
      s1_din_q   <= s0_din_q;
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_addr_q;
      s2_din_q   <= s1_din_q;
      s2_old_q   <= s1_old;
      wb_valid_q <= s2_valid_q;
      wb_addr_q  <= s2_addr_q;
      wb_entry_q <= s2_new;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;
  assign rd_value = rd_value_q;
  assign rd_count = rd_count_q;
  assign err      = err_q;

endmodule
